// File: rtl/ice_spi_pkg.sv
// rtl/ice_spi_pkg.sv - shared types and helpers for the SPI readout buffer
// Purpose: FSM state type, default geometry, slice/count helper localparams
//          and the lane-count legality check used at elaboration.
// Ports:   none (package).
package ice_spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int DEF_W_IN  = 16;
  localparam int DEF_LANES = 8;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_CHUNK = 64;

  // Slices per word and level counter width for the default geometry.
  localparam int SPW   = DEF_W_IN / DEF_LANES;
  localparam int CNT_W = $clog2(DEF_DEPTH + 1);

  // Lanes must be a supported bus width and split a word evenly.
  function automatic bit lanes_ok(input int lanes, input int w_in);
    return ((lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8)) &&
           ((w_in % lanes) == 0);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with registered in_ready and level
// Purpose: word store for readout paths; en=0 empties it synchronously.
// Ports:
//   clk, rst_      clock, asynchronous active-low reset
//   en             0 = flush pointers/level and refuse pushes
//   in_valid/in_ready/in_data   push handshake (push = in_valid & in_ready)
//   pop            remove head word this cycle (caller guarantees non-empty)
//   head           word at the read pointer
//   level          words currently held
module fifo_sync #(
  parameter int W     = 16,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] level_nxt;
  logic          push;

  assign push = in_valid & in_ready;
  assign head = mem[rptr];

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level - LW'(1);
    end
  end

  // in_ready is computed from the level this edge produces, so a full FIFO
  // refuses the next push even if a pop lands in that same cycle.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      in_ready <= 1'b0;
    end else if (!en) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      level    <= level_nxt;
      in_ready <= (level_nxt < LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

endmodule

// File: rtl/spi_readout_buffer.sv
// rtl/spi_readout_buffer.sv - chunked readout FIFO serialised onto SPI lanes
// Purpose: buffers readout words, arms d_ready once a full chunk is held and
//          shifts that chunk out MSB-first, one LANES-wide slice per trigger.
// Ports:
//   clk, rst_      clock, asynchronous active-low reset
//   en             0 = synchronous flush to idle
//   in_valid/in_ready/in_data   readout word push handshake
//   out_trigger    strobe: SPI consumed the current slice
//   out_data       current slice (0 when nothing is armed)
//   d_ready        chunk armed, waiting for its first trigger
//   underrun       sticky: trigger arrived while idle
//   level          words held in the FIFO
module spi_readout_buffer
  import ice_spi_pkg::*;
#(
  parameter int W_IN  = DEF_W_IN,
  parameter int LANES = DEF_LANES,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W_IN-1:0]            in_data,
  input  logic                       out_trigger,
  output logic [LANES-1:0]           out_data,
  output logic                       d_ready,
  output logic                       underrun,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int SLICES = W_IN / LANES;
  localparam int SC_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int WL_W   = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  if (!lanes_ok(LANES, W_IN)) begin : g_bad_lanes
    $error("spi_readout_buffer: illegal LANES");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("spi_readout_buffer: illegal DEPTH");
  end
  if ((CHUNK < 1) || (CHUNK > DEPTH)) begin : g_bad_chunk
    $error("spi_readout_buffer: illegal CHUNK");
  end

  state_t          state, state_nxt;
  logic [W_IN-1:0] shreg, shreg_nxt;
  logic [SC_W-1:0] slice_cnt, slice_cnt_nxt;
  logic [WL_W-1:0] words_left, words_left_nxt;
  logic            d_ready_nxt;
  logic            underrun_nxt;
  logic            pop;
  logic [W_IN-1:0] head;

  fifo_sync #(
    .W     (W_IN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_     (rst_),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .pop      (pop),
    .head     (head),
    .level    (level)
  );

  // The slice on the bus is always the top LANES bits of the shift register;
  // clearing the register is what drives out_data to 0 when idle.
  assign out_data = shreg[W_IN-1 -: LANES];

  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    slice_cnt_nxt  = slice_cnt;
    words_left_nxt = words_left;
    d_ready_nxt    = d_ready;
    underrun_nxt   = underrun;
    pop            = 1'b0;
    case (state)
      IDLE: begin
        if (out_trigger) underrun_nxt = 1'b1;
        // Arming pops the first word immediately; the remaining CHUNK-1 words
        // are already counted in level, so later pops can never find it empty.
        if (level >= LVL_W'(CHUNK)) begin
          pop            = 1'b1;
          shreg_nxt      = head;
          slice_cnt_nxt  = '0;
          words_left_nxt = WL_W'(CHUNK - 1);
          d_ready_nxt    = 1'b1;
          state_nxt      = ARMED;
        end
      end
      ARMED, STREAM: begin
        if (out_trigger) begin
          d_ready_nxt = 1'b0;
          state_nxt   = STREAM;
          if (slice_cnt != SC_W'(SLICES - 1)) begin
            slice_cnt_nxt = slice_cnt + SC_W'(1);
            shreg_nxt     = shreg << LANES;
          end else if (words_left != '0) begin
            pop            = 1'b1;
            shreg_nxt      = head;
            slice_cnt_nxt  = '0;
            words_left_nxt = words_left - WL_W'(1);
          end else begin
            shreg_nxt = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        shreg_nxt   = '0;
        d_ready_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      shreg      <= '0;
      slice_cnt  <= '0;
      words_left <= '0;
      d_ready    <= 1'b0;
      underrun   <= 1'b0;
    end else if (!en) begin
      state      <= IDLE;
      shreg      <= '0;
      slice_cnt  <= '0;
      words_left <= '0;
      d_ready    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      slice_cnt  <= slice_cnt_nxt;
      words_left <= words_left_nxt;
      d_ready    <= d_ready_nxt;
      underrun   <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_spi_readout_buffer.sv
// tb/tb_spi_readout_buffer.sv - self-checking bench for spi_readout_buffer
module tb_spi_readout_buffer;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        en = 1'b0;
  logic [15:0] din = '0;
  logic [1:0]  vin = '0;
  logic [1:0]  trig = '0;

  logic       in_ready_a, d_ready_a, underrun_a;
  logic [7:0] out_a;
  logic [8:0] level_a;
  logic       in_ready_b, d_ready_b, underrun_b;
  logic [1:0] out_b;
  logic [2:0] level_b;

  always #5 clk = ~clk;

  spi_readout_buffer #(.W_IN(16), .LANES(8), .DEPTH(256), .CHUNK(64)) dut_a (
    .clk(clk), .rst_(rst_), .en(en), .in_valid(vin[0]), .in_ready(in_ready_a),
    .in_data(din), .out_trigger(trig[0]), .out_data(out_a), .d_ready(d_ready_a),
    .underrun(underrun_a), .level(level_a)
  );

  spi_readout_buffer #(.W_IN(16), .LANES(2), .DEPTH(4), .CHUNK(4)) dut_b (
    .clk(clk), .rst_(rst_), .en(en), .in_valid(vin[1]), .in_ready(in_ready_b),
    .in_data(din), .out_trigger(trig[1]), .out_data(out_b), .d_ready(d_ready_b),
    .underrun(underrun_b), .level(level_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: word queue + current word/slice -------
  logic [15:0] fq [2][256];
  int          fhead [2];
  int          fcnt [2];
  int          mode [2];     // 0 idle, 1 armed, 2 streaming
  logic [15:0] cur [2];
  int          kk [2];
  int          wl [2];
  bit          pushed [2];
  logic        e_in_ready [2];
  logic        e_d_ready [2];
  logic        e_underrun [2];
  logic [7:0]  e_out [2];
  int          e_level [2];

  function automatic int m_lanes(input int i); return (i == 0) ? 8 : 2; endfunction
  function automatic int m_chunk(input int i); return (i == 0) ? 64 : 4; endfunction
  function automatic int m_depth(input int i); return (i == 0) ? 256 : 4; endfunction

  function automatic logic [7:0] slc(input logic [15:0] w, input int k, input int lanes);
    logic [15:0] t;
    t = w >> (16 - (k + 1) * lanes);
    return t[7:0] & 8'((1 << lanes) - 1);
  endfunction

  task automatic model_reset(input int i);
    fhead[i] = 0; fcnt[i] = 0; mode[i] = 0; cur[i] = '0; kk[i] = 0; wl[i] = 0;
    pushed[i] = 1'b0;
    e_in_ready[i] = 1'b0; e_d_ready[i] = 1'b0; e_underrun[i] = 1'b0;
    e_out[i] = '0; e_level[i] = 0;
  endtask

  task automatic model_pop(input int i);
    cur[i]   = fq[i][fhead[i]];
    fhead[i] = (fhead[i] + 1) % m_depth(i);
    fcnt[i]--;
    kk[i]    = 0;
    e_out[i] = slc(cur[i], 0, m_lanes(i));
  endtask

  task automatic model_step(input int i);
    bit push;
    pushed[i] = 1'b0;
    if (!rst_ || !en) begin
      model_reset(i);
      return;
    end
    push = vin[i] && e_in_ready[i];
    if (mode[i] == 0) begin
      if (trig[i]) e_underrun[i] = 1'b1;
      if (fcnt[i] >= m_chunk(i)) begin
        model_pop(i);
        wl[i] = m_chunk(i) - 1;
        e_d_ready[i] = 1'b1;
        mode[i] = 1;
      end
    end else if (trig[i]) begin
      e_d_ready[i] = 1'b0;
      mode[i] = 2;
      if (kk[i] < 16 / m_lanes(i) - 1) begin
        kk[i]++;
        e_out[i] = slc(cur[i], kk[i], m_lanes(i));
      end else if (wl[i] > 0) begin
        model_pop(i);
        wl[i]--;
      end else begin
        e_out[i] = '0;
        mode[i] = 0;
      end
    end
    if (push) begin
      fq[i][(fhead[i] + fcnt[i]) % m_depth(i)] = din;
      fcnt[i]++;
      pushed[i] = 1'b1;
    end
    e_level[i]    = fcnt[i];
    e_in_ready[i] = (fcnt[i] < m_depth(i));
  endtask

  // ---------------- per-cycle compare --------------------------------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a.in_ready", in_ready_a, e_in_ready[0]);
      chk("a.d_ready",  d_ready_a,  e_d_ready[0]);
      chk("a.underrun", underrun_a, e_underrun[0]);
      chk("a.out_data", out_a,      e_out[0]);
      chk("a.level",    level_a,    e_level[0]);
      chk("b.in_ready", in_ready_b, e_in_ready[1]);
      chk("b.d_ready",  d_ready_b,  e_d_ready[1]);
      chk("b.underrun", underrun_b, e_underrun[1]);
      chk("b.out_data", {6'b0, out_b}, e_out[1]);
      chk("b.level",    level_b,    e_level[1]);
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #2;
  endtask

  task automatic push_word(input int i, input logic [15:0] d);
    bit done;
    done = 1'b0;
    vin[i] = 1'b1;
    din = d;
    for (int n = 0; n < 20 && !done; n++) begin
      cyc();
      done = pushed[i];
    end
    vin[i] = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic trig_once(input int i);
    trig[i] = 1'b1;
    cyc();
    trig[i] = 1'b0;
  endtask

  function automatic logic [15:0] wa(input int i);
    logic [7:0] lo;
    lo = 8'(i);
    return {8'h5A + lo, lo};
  endfunction

  logic [1:0]  pat [8];
  logic [15:0] first_w;

  initial begin
    pat = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11};
    model_reset(0);
    model_reset(1);
    chk_on = 1'b1;

    // reset state
    cyc(); cyc();
    chk("rst.in_ready", in_ready_a, 0);
    chk("rst.d_ready",  d_ready_a,  0);
    chk("rst.underrun", underrun_a, 0);
    chk("rst.out_data", out_a,      0);
    chk("rst.level",    level_a,    0);
    rst_ = 1'b1;
    en   = 1'b1;
    cyc();

    // 63 words do not arm; the 64th arms two edges after its push
    for (int i = 0; i < 63; i++) push_word(0, wa(i));
    repeat (4) cyc();
    chk("t1.d_ready_63", d_ready_a, 0);
    chk("t1.level_63",   level_a,   63);
    push_word(0, wa(63));
    chk("t1.level_64",   level_a,   64);
    chk("t1.d_ready_lat", d_ready_a, 0);
    cyc();
    chk("t1.d_ready_arm", d_ready_a, 1);
    chk("t1.out_first",   out_a,     8'h5A);

    // stream the chunk out: 128 bytes, MSB byte first
    trig_once(0);
    chk("t2.d_ready_drop", d_ready_a, 0);
    chk("t2.byte1",        out_a,     8'h00);
    trig_once(0);
    chk("t2.byte2",        out_a,     8'h5B);
    for (int t = 3; t <= 128; t++) trig_once(0);
    chk("t2.out_end",   out_a,     0);
    chk("t2.level_end", level_a,   0);
    chk("t2.d_ready_end", d_ready_a, 0);

    // underrun while idle, cleared by a one-cycle flush
    for (int i = 0; i < 10; i++) push_word(0, wa(i));
    trig_once(0);
    chk("t4.underrun",  underrun_a, 1);
    chk("t4.out_zero",  out_a,      0);
    chk("t4.level10",   level_a,    10);
    repeat (3) cyc();
    chk("t4.sticky",    underrun_a, 1);
    en = 1'b0;
    cyc();
    en = 1'b1;
    chk("t4.flush_underrun", underrun_a, 0);
    chk("t4.flush_level",    level_a,    0);
    chk("t4.flush_in_ready", in_ready_a, 0);
    cyc();
    chk("t4.in_ready_back",  in_ready_a, 1);

    // LANES=2 CHUNK=DEPTH=4: full-FIFO in_ready, single freed push, slices
    for (int i = 0; i < 4; i++) push_word(1, 16'hA5C3);
    chk("t5.level_full",    level_b,    4);
    chk("t5.in_ready_full", in_ready_b, 0);
    chk("t5.d_ready_pre",   d_ready_b,  0);
    cyc();
    chk("t5.d_ready_arm",   d_ready_b,  1);
    chk("t5.level_pop",     level_b,    3);
    chk("t5.in_ready_free", in_ready_b, 1);
    chk("t5.slice0",        out_b,      pat[0]);
    push_word(1, 16'h1234);
    chk("t5.level_refill",  level_b,    4);
    chk("t5.in_ready_refull", in_ready_b, 0);
    for (int t = 1; t <= 32; t++) begin
      trig_once(1);
      if (t == 1) chk("t5.d_ready_drop", d_ready_b, 0);
      if (t < 32) chk($sformatf("t5.slice%0d", t), out_b, pat[t % 8]);
      else        chk("t5.out_end", out_b, 0);
    end
    chk("t5.level_after", level_b, 1);

    // asynchronous reset mid-chunk, then a fresh chunk arms normally
    for (int i = 0; i < 64; i++) push_word(0, 16'($urandom));
    cyc();
    chk("t6.armed", d_ready_a, 1);
    for (int t = 0; t < 50; t++) trig_once(0);
    #1 rst_ = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("t6.rst_out",      out_a,      0);
    chk("t6.rst_d_ready",  d_ready_a,  0);
    chk("t6.rst_level",    level_a,    0);
    chk("t6.rst_in_ready", in_ready_a, 0);
    chk("t6.rst_b_level",  level_b,    0);
    repeat (2) cyc();
    rst_ = 1'b1;
    cyc();
    first_w = 16'($urandom);
    push_word(0, first_w);
    for (int i = 1; i < 64; i++) push_word(0, 16'($urandom));
    cyc();
    chk("t6.rearm",     d_ready_a, 1);
    chk("t6.rearm_out", out_a,     {24'd0, first_w[15:8]});

    // randomized traffic on both instances, checked every cycle by the model
    for (int n = 0; n < 4000; n++) begin
      en  = ($urandom_range(0, 499) != 0);
      din = 16'($urandom);
      for (int j = 0; j < 2; j++) begin
        vin[j]  = ($urandom_range(0, 9) < 6);
        trig[j] = (mode[j] != 0) ? ($urandom_range(0, 9) < 4)
                                 : ($urandom_range(0, 49) == 0);
      end
      cyc();
    end
    vin  = '0;
    trig = '0;
    en   = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    #1;
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
